hcsr04_ranger: RTL and testbench



---
 rtl/hcsr04_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/hcsr04_ranger.sv | 135 +++++++++++++
 tb/tb_hcsr04_ranger.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// rtl/hcsr04_pkg.sv - shared state encoding and 25 MHz timing defaults for the HC-SR04 ranger
package hcsr04_pkg;

  // Ranger FSM state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_FAIL      = 3'd5;
  localparam logic [2:0] ST_HOLD      = 3'd6;

  // Board clock and the sensor timings derived from it
  localparam int CLK_HZ                = 25_000_000;
  localparam int DEF_TRIG_CYCLES       = CLK_HZ / 100_000;         // 10 us
  localparam int DEF_PERIOD_CYCLES     = (CLK_HZ / 1000) * 60;     // 60 ms
  localparam int DEF_TIMEOUT_CYCLES    = (CLK_HZ / 1000) * 38;     // 38 ms
  localparam int DEF_CYCLES_PER_CM     = (CLK_HZ / 1_000_000) * 58; // 58 us per cm
  localparam int DEF_DIST_W            = 9;

  // Counter width able to hold 0..limit-1, never narrower than one bit
  function automatic int cnt_w(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous input pins
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hcsr04_ranger.sv
// rtl/hcsr04_ranger.sv - HC-SR04 trigger generation and echo-width to centimetre conversion
module hcsr04_ranger
  import hcsr04_pkg::*;
#(
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
  parameter int DIST_W         = DEF_DIST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              echo,
  output logic              trigger,
  output logic [DIST_W-1:0] distance_cm,
  output logic              distance_valid,
  output logic              timeout,
  output logic              busy
);

  localparam int PER_W = cnt_w(PERIOD_CYCLES);
  localparam int TO_W  = cnt_w(TIMEOUT_CYCLES);
  localparam int SUB_W = cnt_w(CYCLES_PER_CM);

  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [PER_W-1:0]  TRIG_LAST = PER_W'(TRIG_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_MAX    = {DIST_W{1'b1}};

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [PER_W-1:0]  per_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [SUB_W-1:0]  sub_cnt;
  logic [DIST_W-1:0] cm;
  logic              echo_s;
  logic              per_wrap;
  logic              to_hit;
  logic              waiting;
  logic              count_en;

  sync_2ff #(.WIDTH(1)) u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo),
    .q     (echo_s)
  );

  assign per_wrap = (per_cnt == PER_LAST);
  assign to_hit   = (to_cnt == TO_LAST);
  assign waiting  = (state == ST_WAIT_RISE) || (state == ST_MEASURE);
  // Count every synchronized echo-high cycle, including the one that ends WAIT_RISE,
  // so an echo already high on entry is measured from its first cycle
  assign count_en = waiting && echo_s;

  // Next-state decode; echo falling wins over a coincident timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (enable) state_nxt = ST_TRIG;
      ST_TRIG:      if (per_cnt == TRIG_LAST) state_nxt = ST_WAIT_RISE;
      ST_WAIT_RISE: begin
        if (echo_s)      state_nxt = ST_MEASURE;
        else if (to_hit) state_nxt = ST_FAIL;
      end
      ST_MEASURE:   begin
        if (!echo_s)     state_nxt = ST_DONE;
        else if (to_hit) state_nxt = ST_FAIL;
      end
      ST_DONE,
      ST_FAIL:      state_nxt = ST_HOLD;
      ST_HOLD:      if (per_wrap) state_nxt = enable ? ST_TRIG : ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Period counter: zero in IDLE, so it reads 0 on the first TRIG cycle and wraps back into TRIG
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  per_cnt <= '0;
    else if (state == ST_IDLE)   per_cnt <= '0;
    else if (per_wrap)           per_cnt <= '0;
    else                         per_cnt <= per_cnt + PER_W'(1);
  end

  // Shared echo timeout: runs across WAIT_RISE and MEASURE without restarting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       to_cnt <= '0;
    else if (waiting) to_cnt <= to_cnt + TO_W'(1);
    else              to_cnt <= '0;
  end

  // Repeated-subtraction divider: sub_cnt counts cycles within the current cm, cm saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      cm      <= '0;
    end else if (state == ST_TRIG) begin
      sub_cnt <= '0;
      cm      <= '0;
    end else if (count_en) begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        if (cm != CM_MAX) cm <= cm + DIST_W'(1);
      end else begin
        sub_cnt <= sub_cnt + SUB_W'(1);
      end
    end
  end

  // Outputs registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger        <= 1'b0;
      busy           <= 1'b0;
      distance_valid <= 1'b0;
      timeout        <= 1'b0;
      distance_cm    <= '0;
    end else begin
      trigger        <= (state_nxt == ST_TRIG);
      busy           <= (state_nxt != ST_IDLE);
      distance_valid <= (state_nxt == ST_DONE);
      timeout        <= (state_nxt == ST_FAIL);
      if (state_nxt == ST_DONE) distance_cm <= cm;
    end
  end

endmodule

// File: tb/tb_hcsr04_ranger.sv
// tb/tb_hcsr04_ranger.sv - directed self-checking bench for hcsr04_ranger
module tb_hcsr04_ranger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, echo;
  logic       trigger, distance_valid, timeout, busy;
  logic [8:0] distance_cm;
  logic       enable4, echo4;
  logic       trigger4, valid4, timeout4, busy4;
  logic [3:0] dist4;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // event indices: 0 rise, 1 fall, 2 valid, 3 timeout, 4 fall4, 5 valid4, 6 timeout4
  int   n_ev[7];
  int   ev_cyc[7];
  int   prev_rise = 0;
  logic trig_q = 1'b0, trig4_q = 1'b0;

  hcsr04_ranger #(
    .TRIG_CYCLES(4), .PERIOD_CYCLES(400), .TIMEOUT_CYCLES(200), .CYCLES_PER_CM(2), .DIST_W(9)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo), .trigger(trigger),
    .distance_cm(distance_cm), .distance_valid(distance_valid), .timeout(timeout), .busy(busy)
  );

  hcsr04_ranger #(
    .TRIG_CYCLES(4), .PERIOD_CYCLES(400), .TIMEOUT_CYCLES(200), .CYCLES_PER_CM(2), .DIST_W(4)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable4), .echo(echo4), .trigger(trigger4),
    .distance_cm(dist4), .distance_valid(valid4), .timeout(timeout4), .busy(busy4)
  );

  always #20 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // event monitor sampled on the falling edge
  always @(negedge clk) begin
    trig_q  <= trigger;
    trig4_q <= trigger4;
    if (trigger && !trig_q) begin
      n_ev[0] <= n_ev[0] + 1; prev_rise <= ev_cyc[0]; ev_cyc[0] <= cyc;
    end
    if (!trigger && trig_q)  begin n_ev[1] <= n_ev[1] + 1; ev_cyc[1] <= cyc; end
    if (distance_valid)      begin n_ev[2] <= n_ev[2] + 1; ev_cyc[2] <= cyc; end
    if (timeout)             begin n_ev[3] <= n_ev[3] + 1; ev_cyc[3] <= cyc; end
    if (!trigger4 && trig4_q) begin n_ev[4] <= n_ev[4] + 1; ev_cyc[4] <= cyc; end
    if (valid4)              begin n_ev[5] <= n_ev[5] + 1; ev_cyc[5] <= cyc; end
    if (timeout4)            begin n_ev[6] <= n_ev[6] + 1; ev_cyc[6] <= cyc; end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_evt(input int idx, input int bound, input string tag);
    int start;
    int k;
    start = n_ev[idx];
    k = 0;
    while (n_ev[idx] == start && k < bound) begin
      step(1);
      k++;
    end
    check_eq(tag, int'(n_ev[idx] != start), 1);
  endtask

  task automatic measure(input int dly, input int width, input int exp_cm, input string tag);
    int n;
    int v0;
    step(dly);
    echo = 1'b1;
    step(width);
    echo = 1'b0;
    n  = cyc;
    v0 = n_ev[2];
    wait_evt(2, 20, {tag, "_valid_seen"});
    check_eq({tag, "_latency"}, ev_cyc[2] - n, 3);
    check_eq({tag, "_cm"}, int'(distance_cm), exp_cm);
    step(4);
    check_eq({tag, "_valid_pulses"}, n_ev[2] - v0, 1);
  endtask

  initial begin
    int hi;
    int k;
    int t0;
    int v0;
    int r0;
    foreach (n_ev[i]) begin n_ev[i] = 0; ev_cyc[i] = 0; end
    rst_n = 1'b0; enable = 1'b1; echo = 1'b0; enable4 = 1'b0; echo4 = 1'b0;

    step(3);
    check_eq("rst_trigger", int'(trigger), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_cm", int'(distance_cm), 0);
    check_eq("rst_valid", int'(distance_valid), 0);
    check_eq("rst_timeout", int'(timeout), 0);

    rst_n = 1'b1;
    step(1);
    check_eq("trig_first_cycle", int'(trigger), 1);
    check_eq("busy_in_trig", int'(busy), 1);
    hi = 1; k = 0;
    while (trigger && k < 20) begin
      step(1);
      k++;
      if (trigger) hi++;
    end
    check_eq("trig_width", hi, 4);
    check_eq("no_valid_yet", n_ev[2], 0);
    check_eq("no_timeout_yet", n_ev[3], 0);

    measure(10, 80, 40, "m80");

    wait_evt(1, 500, "m1_fall_seen");
    check_eq("period_1", ev_cyc[0] - prev_rise, 400);
    measure(10, 1, 0, "m1");

    wait_evt(1, 500, "m81_fall_seen");
    measure(10, 81, 40, "m81");

    wait_evt(1, 500, "to_fall_seen");
    t0 = ev_cyc[1];
    v0 = n_ev[2];
    wait_evt(3, 300, "to_seen");
    check_eq("to_delay", ev_cyc[3] - t0, 200);
    check_eq("to_cm_kept", int'(distance_cm), 40);
    check_eq("to_no_valid", n_ev[2] - v0, 0);
    step(2);
    check_eq("to_pulse_width", n_ev[3], 1);

    wait_evt(1, 500, "en_fall_seen");
    check_eq("period_after_to", ev_cyc[0] - prev_rise, 400);
    step(10);
    echo = 1'b1;
    step(10);
    enable = 1'b0;
    step(10);
    echo = 1'b0;
    k = cyc;
    wait_evt(2, 20, "en_valid_seen");
    check_eq("en_latency", ev_cyc[2] - k, 3);
    check_eq("en_cm", int'(distance_cm), 10);
    r0 = n_ev[0];
    step(450);
    check_eq("en_no_retrigger", n_ev[0] - r0, 0);
    check_eq("en_idle_busy", int'(busy), 0);

    enable = 1'b1;
    wait_evt(1, 20, "rst_fall_seen");
    step(5);
    echo = 1'b1;
    step(20);
    #5 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_trigger", int'(trigger), 0);
    check_eq("mid_rst_cm", int'(distance_cm), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_valid", int'(distance_valid), 0);
    check_eq("mid_rst_timeout", int'(timeout), 0);
    echo = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    check_eq("restart_trigger", int'(trigger), 1);
    check_eq("restart_busy", int'(busy), 1);
    enable = 1'b0;

    enable4 = 1'b1;
    wait_evt(4, 20, "sat_fall_seen");
    echo4 = 1'b1;
    wait_evt(6, 300, "sat_timeout_seen");
    check_eq("sat_cm_not_loaded", int'(dist4), 0);
    check_eq("sat_no_valid", n_ev[5], 0);
    step(3);
    echo4 = 1'b0;
    wait_evt(4, 500, "sat2_fall_seen");
    step(5);
    echo4 = 1'b1;
    step(40);
    echo4 = 1'b0;
    wait_evt(5, 20, "sat2_valid_seen");
    check_eq("sat2_cm", int'(dist4), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
